// File: rtl/seq_shifter_if.sv
// Command/result handshake bundle for seq_shifter.
// Carries the carry output only when SEQ_SHIFTER_CARRY_EN is defined.
interface seq_shifter_if #(
    parameter int W   = 16,
    parameter int SHW = 5
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   din;
    logic [1:0]     mode;
    logic [SHW-1:0] shamt;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   dout;
`ifdef SEQ_SHIFTER_CARRY_EN
    logic           carry;
`endif

    modport master (
        output in_valid, din, mode, shamt, out_ready,
`ifdef SEQ_SHIFTER_CARRY_EN
        input  carry,
`endif
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, din, mode, shamt, out_ready,
`ifdef SEQ_SHIFTER_CARRY_EN
        output carry,
`endif
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter, up to STEP positions per clock, valid/ready on both sides.
// Optional macro SEQ_SHIFTER_CARRY_EN adds a carry output holding the last bit shifted out.
module seq_shifter #(
    parameter int W    = 16,
    parameter int SHW  = 5,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          reset,
    seq_shifter_if.slave  bus
);
    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   result_reg;
    logic [1:0]     mode_reg;
    logic [SHW-1:0] rem_reg, rem_next;
    logic [W-1:0]   shifted;
    logic [31:0]    rem_ext;
    logic [31:0]    k;

    function automatic logic [W-1:0] shift_one(input logic [W-1:0] x, input logic [1:0] m);
        case (m)
            MODE_LSL: shift_one = {x[W-2:0], 1'b0};
            MODE_LSR: shift_one = {1'b0, x[W-1:1]};
            MODE_ASR: shift_one = {x[W-1], x[W-1:1]};
            default:  shift_one = {x[0], x[W-1:1]};
        endcase
    endfunction

`ifdef SEQ_SHIFTER_CARRY_EN
    logic carry_reg;
    logic shift_carry;

    function automatic logic out_bit(input logic [W-1:0] x, input logic [1:0] m);
        out_bit = (m == MODE_LSL) ? x[W-1] : x[0];
    endfunction
`endif

    assign rem_ext  = 32'(rem_reg);
    assign k        = (rem_ext > STEP) ? STEP : rem_ext;
    assign rem_next = rem_reg - SHW'(k);

    // Chain of single-bit stages; stage i is active only while i < rem.
    always_comb begin
        shifted = result_reg;
`ifdef SEQ_SHIFTER_CARRY_EN
        shift_carry = carry_reg;
`endif
        for (int i = 0; i < STEP; i++) begin
            if (rem_ext > 32'(i)) begin
`ifdef SEQ_SHIFTER_CARRY_EN
                shift_carry = out_bit(shifted, mode_reg);
`endif
                shifted = shift_one(shifted, mode_reg);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid) state_next = (bus.shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (rem_next == '0) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            mode_reg   <= MODE_LSL;
            rem_reg    <= '0;
`ifdef SEQ_SHIFTER_CARRY_EN
            carry_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.in_valid) begin
                result_reg <= bus.din;
                mode_reg   <= bus.mode;
                rem_reg    <= bus.shamt;
`ifdef SEQ_SHIFTER_CARRY_EN
                carry_reg  <= 1'b0;
`endif
            end else if (state_reg == SHIFT) begin
                result_reg <= shifted;
                rem_reg    <= rem_next;
`ifdef SEQ_SHIFTER_CARRY_EN
                carry_reg  <= shift_carry;
`endif
            end
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.dout      = result_reg;
`ifdef SEQ_SHIFTER_CARRY_EN
    assign bus.carry     = carry_reg;
`endif

    // MODE_LSR/ASR/ROR named for readability in shift_one; ROR falls in the default arm.
    logic unused_modes;
    assign unused_modes = ^{MODE_LSR, MODE_ASR, MODE_ROR};
endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: a STEP=1 and a STEP=4 instance share one command stream.
module tb_seq_shifter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_shifter_if #(.W(16), .SHW(5)) bus_a ();
    seq_shifter_if #(.W(16), .SHW(5)) bus_b ();

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.din       = bus_a.din;
    assign bus_b.mode      = bus_a.mode;
    assign bus_b.shamt     = bus_a.shamt;
    assign bus_b.out_ready = bus_a.out_ready;

    seq_shifter #(.W(16), .SHW(5), .STEP(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    seq_shifter #(.W(16), .SHW(5), .STEP(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_a_in_ready"},  32'(bus_a.in_ready),  32'd1);
        chk({tag, "_a_out_valid"}, 32'(bus_a.out_valid), 32'd0);
        chk({tag, "_a_dout"},      32'(bus_a.dout),      32'd0);
        chk({tag, "_b_in_ready"},  32'(bus_b.in_ready),  32'd1);
        chk({tag, "_b_out_valid"}, 32'(bus_b.out_valid), 32'd0);
        chk({tag, "_b_dout"},      32'(bus_b.dout),      32'd0);
`ifdef SEQ_SHIFTER_CARRY_EN
        chk({tag, "_a_carry"},     32'(bus_a.carry),     32'd0);
`endif
    endtask

    // Issue one command, measure accept-edge-to-out_valid latency of both instances, check result.
    task automatic run_cmd(input string tag, input logic [15:0] d, input logic [1:0] m,
                           input logic [4:0] s, input logic [15:0] exp, input logic exp_c,
                           input int lat_a_exp, input int lat_b_exp);
        int cyc, lat_a, lat_b;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus_a.in_ready), 32'd1);
        bus_a.in_valid = 1'b1;
        bus_a.din      = d;
        bus_a.mode     = m;
        bus_a.shamt    = s;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        bus_a.din      = ~d;
        bus_a.mode     = ~m;
        bus_a.shamt    = ~s;
        cyc = 1; lat_a = 0; lat_b = 0;
        while (cyc < 100) begin
            if (bus_a.out_valid && lat_a == 0) lat_a = cyc;
            if (bus_b.out_valid && lat_b == 0) lat_b = cyc;
            if (lat_a != 0 && lat_b != 0) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_lat_a"},  32'(lat_a),      32'(lat_a_exp));
        chk({tag, "_lat_b"},  32'(lat_b),      32'(lat_b_exp));
        chk({tag, "_dout_a"}, 32'(bus_a.dout), 32'(exp));
        chk({tag, "_dout_b"}, 32'(bus_b.dout), 32'(exp));
        chk({tag, "_in_ready_done"}, 32'(bus_a.in_ready), 32'd0);
`ifdef SEQ_SHIFTER_CARRY_EN
        chk({tag, "_carry_a"}, 32'(bus_a.carry), 32'(exp_c));
        chk({tag, "_carry_b"}, 32'(bus_b.carry), 32'(exp_c));
`else
        if (exp_c === 1'bz) $display("unreachable");
`endif
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        bus_a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.out_ready = 1'b0;
        chk({tag, "_ack_in_ready"},  32'(bus_a.in_ready),  32'd1);
        chk({tag, "_ack_out_valid"}, 32'(bus_a.out_valid), 32'd0);
        chk({tag, "_ack_b_in_ready"}, 32'(bus_b.in_ready), 32'd1);
    endtask

    initial begin
        bus_a.in_valid  = 1'b0;
        bus_a.din       = '0;
        bus_a.mode      = 2'b00;
        bus_a.shamt     = '0;
        bus_a.out_ready = 1'b0;

        @(posedge clk);
        #2;
        chk_idle_reset("reset");
        @(negedge clk);
        reset = 1'b0;

        run_cmd("lsl1",   16'hF0CF, 2'b00, 5'd1,  16'hE19E, 1'b1, 2,  2);
        ack("lsl1");
        run_cmd("asr4",   16'h8001, 2'b10, 5'd4,  16'hF800, 1'b0, 5,  2);
        ack("asr4");
        run_cmd("lsr4",   16'h8001, 2'b01, 5'd4,  16'h0800, 1'b0, 5,  2);
        ack("lsr4");
        run_cmd("ror20",  16'h1234, 2'b11, 5'd20, 16'h4123, 1'b0, 21, 6);
        ack("ror20");
        run_cmd("lsr0",   16'hABCD, 2'b01, 5'd0,  16'hABCD, 1'b0, 1,  1);
        ack("lsr0");
        run_cmd("asr31",  16'h8001, 2'b10, 5'd31, 16'hFFFF, 1'b1, 32, 9);
        ack("asr31");
        run_cmd("lsl20",  16'hF0CF, 2'b00, 5'd20, 16'h0000, 1'b0, 21, 6);
        ack("lsl20");

        // Backpressure: result must hold and no new command may be taken.
        run_cmd("bp", 16'h8001, 2'b01, 5'd4, 16'h0800, 1'b0, 5, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_a.in_valid = ~bus_a.in_valid;
            bus_a.din      = bus_a.din ^ 16'h5A5A;
            bus_a.shamt    = 5'd0;
            @(posedge clk);
            #1;
            chk("bp_hold_dout",      32'(bus_a.dout),      32'h0800);
            chk("bp_hold_in_ready",  32'(bus_a.in_ready),  32'd0);
            chk("bp_hold_out_valid", 32'(bus_a.out_valid), 32'd1);
        end
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        ack("bp");

        // Asynchronous abort in the middle of a long LSL.
        @(negedge clk);
        bus_a.in_valid = 1'b1;
        bus_a.din      = 16'h0001;
        bus_a.mode     = 2'b00;
        bus_a.shamt    = 5'd10;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_shift_busy", 32'(bus_a.in_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk_idle_reset("abort");
        @(negedge clk);
        reset = 1'b0;

        run_cmd("post_rst", 16'h0001, 2'b00, 5'd10, 16'h0400, 1'b0, 11, 4);
        ack("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Parametrised multi-cycle shifter, successor to the single-bit datapath shifter.
- Shifts a W-bit operand by a run-time amount in one of four modes, at up to STEP bit positions per clock.
- Uses valid/ready handshakes on both input and output.
- Sits between the B-operand register and the ALU in multi-cycle datapath configurations that need arbitrary shift amounts and rotates.

Parameters:
W, 16, operand/result width in bits (>= 2)
SHW, 5, shift-amount field width; shamt range 0 .. 2^SHW-1
STEP, 1, maximum bit positions shifted per cycle (1 .. W-1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand/command valid
in_ready  output  1  block can accept a command (high only in IDLE)
din  input  W  operand
mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
shamt  input  SHW  shift amount
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
dout  output  W  shifted result

Behaviour:
- Reset (asynchronous, active-high): state IDLE, in_ready=1, out_valid=0, dout=0, internal count=0. Effect is immediate, not clock-gated.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE: on in_valid && in_ready, latch din into the result register, latch mode, and set rem=shamt.
  - If shamt==0, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT: each cycle shift the result register by k = min(STEP, rem) positions in the latched mode, then set rem = rem - k. Enter DONE on the cycle rem becomes 0.
- Mode rules, per step:
  - LSL: zero fill at LSB.
  - LSR: zero fill at MSB.
  - ASR: fill with the current MSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Amounts >= W are executed literally:
  - LSL/LSR give 0.
  - ASR gives all-sign.
  - ROR is equivalent to rotation by shamt mod W.
- Latency: accept edge to out_valid = 1 + ceil(shamt/STEP) cycles. The shamt==0 case gives 1 cycle.
- DONE: dout holds stable while out_valid && !out_ready. On out_ready, go to IDLE on the next edge. in_ready goes high only in IDLE, so there is no same-cycle accept of a new command in DONE.
- dout is the result register itself: registered, and stable in DONE.
- in_valid is ignored outside IDLE. din/mode/shamt changes after acceptance have no effect.
- Reset asserted in SHIFT or DONE aborts the operation with no output and returns all outputs to reset values.
- No combinational path from in_valid/out_ready to any output.

Optional Feature:
Macro SEQ_SHIFTER_CARRY_EN.
- Defined: adds output port carry (1 bit). carry holds the last bit shifted out of the operand:
  - LSL: MSB side.
  - LSR/ASR/ROR: LSB side.
  - Updated each SHIFT cycle; for STEP>1 it is the last bit of that step.
  - Cleared to 0 on accept and on reset; remains 0 for shamt==0.
  - Valid while out_valid.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- W=16, STEP=1: din=16'hF0CF, LSL, shamt=1 -> out_valid 2 cycles after accept, dout=16'hE19E, carry=1.
- ASR, din=16'h8001, shamt=4 -> dout=16'hF800 after 5 cycles, carry=0. Then LSR with the same din -> 16'h0800.
- ROR, din=16'h1234, shamt=20 -> dout=16'h4123 after 21 cycles. Repeat with STEP=4 -> same result after 6 cycles.
- shamt=0, LSR, din=16'hABCD -> dout=16'hABCD after 1 cycle, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/din -> dout stable, in_ready=0, no new accept. Raise out_ready -> IDLE and in_ready=1 on the next edge.
- Assert reset mid-SHIFT (LSL, shamt=10, cycle 4) -> out_valid=0, in_ready=1, dout=0 immediately without a clock edge. After release, the next command completes correctly.
